// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image over 8N1 serial, writes it
// into RAM at LOAD_BASE and releases the CPU from reset once the checksum matches.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 520,
    parameter logic [15:0] LOAD_BASE    = 16'hFF00,
    parameter logic [7:0]  MAGIC        = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        cpu_reset,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_write_en,
    output logic        busy,
    output logic        error,
    output logic        loaded
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_WAIT_MAGIC, P_GET_LEN, P_GET_DATA, P_GET_SUM, P_RUN} p_state_t;

    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t       rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            byte_valid, frame_err;

    p_state_t        p_state_reg, p_state_next;
    logic [7:0]      len_reg, len_next;
    logic [7:0]      index_reg, index_next;
    logic [7:0]      sum_reg, sum_next;
    logic [15:0]     mem_address_reg, mem_address_next;
    logic [7:0]      mem_data_reg, mem_data_next;
    logic            mem_write_en_reg, mem_write_en_next;
    logic            error_reg, error_next;
    logic            cpu_reset_reg, cpu_reset_next;
    logic            loaded_reg, loaded_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg      <= 1'b1;
            rx_sync_reg      <= 1'b1;
            rx_prev_reg      <= 1'b1;
            rx_state_reg     <= RX_IDLE;
            cnt_reg          <= '0;
            bit_reg          <= '0;
            shift_reg        <= '0;
            p_state_reg      <= P_WAIT_MAGIC;
            len_reg          <= '0;
            index_reg        <= '0;
            sum_reg          <= '0;
            mem_address_reg  <= LOAD_BASE;
            mem_data_reg     <= '0;
            mem_write_en_reg <= 1'b0;
            error_reg        <= 1'b0;
            cpu_reset_reg    <= 1'b1;
            loaded_reg       <= 1'b0;
        end else begin
            rx_meta_reg      <= rx;
            rx_sync_reg      <= rx_meta_reg;
            rx_prev_reg      <= rx_sync_reg;
            rx_state_reg     <= rx_state_next;
            cnt_reg          <= cnt_next;
            bit_reg          <= bit_next;
            shift_reg        <= shift_next;
            p_state_reg      <= p_state_next;
            len_reg          <= len_next;
            index_reg        <= index_next;
            sum_reg          <= sum_next;
            mem_address_reg  <= mem_address_next;
            mem_data_reg     <= mem_data_next;
            mem_write_en_reg <= mem_write_en_next;
            error_reg        <= error_next;
            cpu_reset_reg    <= cpu_reset_next;
            loaded_reg       <= loaded_next;
        end
    end

    // Serial receiver; byte_valid / frame_err are single-cycle pulses at the stop-bit sample.
    always_comb begin
        rx_state_next = rx_state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        byte_valid    = 1'b0;
        frame_err     = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = RX_START;
                    cnt_next      = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next      = '0;
                    bit_next      = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next      = '0;
                    rx_state_next = RX_IDLE;
                    byte_valid    = rx_sync_reg;
                    frame_err     = !rx_sync_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Frame protocol; once in RUN nothing on the serial line has any effect.
    always_comb begin
        p_state_next      = p_state_reg;
        len_next          = len_reg;
        index_next        = index_reg;
        sum_next          = sum_reg;
        mem_address_next  = mem_address_reg;
        mem_data_next     = mem_data_reg;
        mem_write_en_next = 1'b0;
        error_next        = error_reg;
        cpu_reset_next    = cpu_reset_reg;
        loaded_next       = loaded_reg;
        if (p_state_reg == P_RUN) begin
            cpu_reset_next = 1'b0;
            loaded_next    = 1'b1;
        end else if (frame_err) begin
            error_next   = 1'b1;
            p_state_next = P_WAIT_MAGIC;
        end else if (byte_valid) begin
            case (p_state_reg)
                P_WAIT_MAGIC: begin
                    if (shift_reg == MAGIC) begin
                        p_state_next = P_GET_LEN;
                        error_next   = 1'b0;
                        sum_next     = '0;
                        index_next   = '0;
                    end
                end
                P_GET_LEN: begin
                    len_next     = shift_reg;
                    p_state_next = P_GET_DATA;
                end
                P_GET_DATA: begin
                    mem_data_next     = shift_reg;
                    mem_address_next  = LOAD_BASE + {8'h00, index_reg};
                    mem_write_en_next = 1'b1;
                    sum_next          = sum_reg + shift_reg;
                    index_next        = index_reg + 8'd1;
                    // A length of 0 wraps to 255 here, giving a 256-byte image.
                    if (index_reg == len_reg - 8'd1) begin
                        p_state_next = P_GET_SUM;
                    end
                end
                P_GET_SUM: begin
                    if (shift_reg == sum_reg) begin
                        p_state_next = P_RUN;
                    end else begin
                        error_next   = 1'b1;
                        p_state_next = P_WAIT_MAGIC;
                    end
                end
                default: p_state_next = P_WAIT_MAGIC;
            endcase
        end
    end

    assign busy         = (p_state_reg == P_GET_LEN) || (p_state_reg == P_GET_DATA) ||
                          (p_state_reg == P_GET_SUM);
    assign cpu_reset    = cpu_reset_reg;
    assign mem_address  = mem_address_reg;
    assign mem_data     = mem_data_reg;
    assign mem_write_en = mem_write_en_reg;
    assign error        = error_reg;
    assign loaded       = loaded_reg;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Serial boot loader placed upstream of the on-chip BlockRAM and CPU6 in the iCE40 top level. After reset it holds the CPU in reset and receives a framed program image over a UART RX pin. It writes the image into the RAM window at LOAD_BASE through the same write port the CPU uses. On a valid checksum it releases cpu_reset; the top level muxes the RAM address, data and write enable to the loader while cpu_reset=1.

Parameters:
CLKS_PER_BIT, 520, clock cycles per serial bit (5 MHz CPU clock / 9600 baud); must be >= 4
LOAD_BASE, 16'hFF00, RAM address written by the first data byte
MAGIC, 8'hA5, frame start byte

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
rx  input  1  UART receive line; idle high, 8N1, LSB first; asynchronous to clock
cpu_reset  output  1  1 = hold CPU6 in reset; 0 = program loaded, CPU running
mem_address  output  16  RAM write address
mem_data  output  8  RAM write data
mem_write_en  output  1  one-cycle RAM write strobe
busy  output  1  1 while a frame is being received (GET_LEN through GET_SUM)
error  output  1  sticky checksum/framing error flag
loaded  output  1  1 once an image has been accepted

Behaviour:
- Reset (async, active-high): cpu_reset=1, mem_write_en=0, mem_address=LOAD_BASE, mem_data=0, busy=0, error=0, loaded=0. Receiver returns to IDLE and protocol FSM to WAIT_MAGIC. Reset mid-frame discards the frame; partial RAM contents are left as written.
- rx passes through a 2-flop synchronizer, preset to 1 on reset. Bit timing uses the synchronized value.
- Receiver FSM: IDLE -> START on a falling edge of synced rx.
- START: wait CLKS_PER_BIT/2 cycles, then sample. If rx=1, treat as a glitch, return to IDLE and produce no byte. Otherwise go to DATA.
- DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, LSB first, then go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample = 1: pulse byte_valid for one cycle with the byte, return to IDLE.
  - Sample = 0: framing error. Set error=1, return to IDLE, force protocol FSM to WAIT_MAGIC.
- Protocol FSM, advanced only on byte_valid:
  - WAIT_MAGIC: byte == MAGIC -> GET_LEN, clear error, clear sum and index. Any other byte is ignored.
  - GET_LEN: latch count N; N=0 means 256. Go to GET_DATA.
  - GET_DATA: on each byte, mem_data=byte and mem_address=LOAD_BASE+{8'h00,index}. Assert mem_write_en on the cycle after byte_valid, for exactly one cycle.
    - sum += byte (8-bit, wraps mod 256); index += 1 (8-bit).
    - After N bytes -> GET_SUM. A 256-byte image wraps index 255 -> 0 with no extra write.
  - GET_SUM: byte == sum -> RUN. Mismatch -> error=1, back to WAIT_MAGIC with cpu_reset still 1.
  - RUN: on the cycle after entry, cpu_reset=0 and loaded=1. Both hold until reset. All rx traffic is ignored and no writes occur.
- busy=1 in GET_LEN, GET_DATA and GET_SUM; 0 otherwise.
- mem_address and mem_data hold their last value between writes. mem_write_en is never asserted outside GET_DATA.
- A new MAGIC arriving mid-frame is treated as data, never as a restart. The only restarts are reset and errors.

Test Plan:
- CLKS_PER_BIT=4; send A5, 03, 11, 22, 33, 66 -> writes FF00=11, FF01=22, FF02=33, each a 1-cycle strobe one clock after the stop-bit sample. cpu_reset falls, loaded=1, error=0.
- Send A5, 02, 10, 20, 31 (bad sum; expected 30) -> two writes occur, error=1, cpu_reset stays 1. Then send A5, 01, 7F, 7F -> error clears on A5, load succeeds, FF00=7F.
- Send A5, 00, then 256 bytes of 01, then sum 00 -> 256 writes FF00..FFFF with no extra write, loaded=1.
- Send a byte with stop bit 0 during GET_DATA -> error=1, no write for that byte, FSM in WAIT_MAGIC. A following non-A5 byte causes no writes.
- Drive a 1-cycle low glitch on rx in IDLE -> no byte_valid, no state change. Then send 3C before A5 -> ignored, no writes.
- Assert reset after the 2nd data byte of a 4-byte frame -> all outputs return to reset values within the same cycle. A full resend loads correctly. After RUN, further rx frames produce no writes.
